// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: pipeline-stage register with valid/ready handshake and 2-entry skid buffer.
// Latency: 1 cycle in->out from EMPTY; 1 entry/cycle sustained while out_ready stays high.
// Backpressure: in_ready drops only when both main and skid hold entries (registered, no ready->ready path).
//
// Ports:
//   clk, reset            rising-edge clock; asynchronous active-low reset
//   flush                 synchronous flush, discards held entries and this cycle's input
//   in_valid/in_ready     upstream handshake; in_data carries FIELDS words of DATA_W bits
//   out_valid/out_ready   downstream handshake; out_data is the main register
//   occupancy             entries held (0..2)
//   stall_cnt, flush_cnt  saturating perf counters, present only when PIPE_SKID_PERF_EN is defined
//
// Optional feature macro: PIPE_SKID_PERF_EN (perf counters and their ports).

module pipe_skid_reg #(
  parameter int DATA_W            = 32,
  parameter int FIELDS            = 5,
  parameter bit FLUSH_CLEARS_DATA = 1'b1,
  parameter int CNT_W             = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [FIELDS*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FIELDS*DATA_W-1:0] out_data,
  output logic [1:0]               occupancy
`ifdef PIPE_SKID_PERF_EN
  ,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt
`endif
);

  localparam int PW = FIELDS * DATA_W;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   main_q, skid_q;
  logic            in_fire, out_fire;
  logic            ld_main_in, ld_main_skid, ld_skid, clr_data;

  // Handshake outputs decode registered state only.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    clr_data     = 1'b0;
    if (flush) begin
      // Flush wins: any accepted input is dropped, held entries discarded.
      state_nxt = EMPTY;
      clr_data  = FLUSH_CLEARS_DATA;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt  = ONE;
            ld_main_in = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            ld_main_in = 1'b1;
          end else if (in_fire) begin
            state_nxt = FULL;
            ld_skid   = 1'b1;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          // Skid entry is younger, so it moves up only after main leaves.
          if (out_fire) begin
            state_nxt    = ONE;
            ld_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Payload registers load only on the transitions above; main keeps stale data while EMPTY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (clr_data) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_in) begin
        main_q <= in_data;
      end else if (ld_main_skid) begin
        main_q <= skid_q;
      end
      if (ld_skid) begin
        skid_q <= in_data;
      end
    end
  end

`ifdef PIPE_SKID_PERF_EN
  // Saturating counters, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush && (state != EMPTY) && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule
